// File: rtl/spectrum_bar_writer.sv
// Bar renderer: loads COLS levels into a load bank, commits them, sweeps ROWS*COLS cells per frame start.
// Latency: first write 1 cycle after registered frame start, then 1 cell/cycle; frame_done 1 cycle after last.
// Backpressure: lvl_ready is always 1 out of reset. Build option SPECTRUM_PEAK_HOLD_EN adds per-column peak markers.
module spectrum_bar_writer #(
  parameter int         COLS       = 32,
  parameter int         ROWS       = 24,
  parameter int         LVL_W      = 5,
  parameter logic [7:0] GREEN_C    = 8'h1C,
  parameter logic [7:0] YELLOW_C   = 8'hFC,
  parameter logic [7:0] RED_C      = 8'hE0,
  parameter logic [7:0] BG_C       = 8'h00,
  parameter logic [7:0] PEAK_C     = 8'hFF,
  parameter int         PEAK_DECAY = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  input  logic             lvl_valid,
  input  logic [LVL_W-1:0] lvl_data,
  output logic             lvl_ready,
  output logic [9:0]       ram_addr,
  output logic [7:0]       write_color,
  output logic             write_en,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0]    COL_LAST  = CW'(COLS - 1);
  localparam logic [9:0]       ADDR_LAST = 10'(COLS * ROWS - 1);
  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(ROWS);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state;
  logic             cond_q, fs;
  logic [LVL_W-1:0] load_bank   [COLS];
  logic [LVL_W-1:0] active_bank [COLS];
  logic [CW-1:0]    ld_cnt;
  logic             commit_pend;
  logic             freeze, commit_now, hs;
  logic [RW-1:0]    row, cur_row;
  logic [CW-1:0]    col, cur_col;
  logic [9:0]       addr, cur_addr;
  logic [LVL_W-1:0] cur_lvl;
  logic [7:0]       cur_color;
  int               cell_h;

  // Active bank is frozen from the frame-start edge until the sweep has fully ended.
  assign freeze     = fs || (state != IDLE);
  assign commit_now = commit_pend && !freeze;
  assign hs         = lvl_valid && lvl_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q <= 1'b0;
      fs     <= 1'b0;
    end else begin
      cond_q <= (hc == 10'd0) && (vc == 10'd0);
      fs     <= (hc == 10'd0) && (vc == 10'd0) && !cond_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_ready   <= 1'b0;
      ld_cnt      <= '0;
      commit_pend <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        load_bank[c]   <= '0;
        active_bank[c] <= '0;
      end
    end else begin
      lvl_ready <= 1'b1;
      if (commit_now) begin
        active_bank <= load_bank;
        commit_pend <= 1'b0;
      end
      if (hs) begin
        load_bank[ld_cnt] <= (lvl_data > LVL_MAX) ? LVL_MAX : lvl_data;
        if (ld_cnt == COL_LAST) begin
          ld_cnt      <= '0;
          commit_pend <= 1'b1;
        end else begin
          ld_cnt <= ld_cnt + CW'(1);
        end
      end
    end
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam int FW = (PEAK_DECAY > 1) ? $clog2(PEAK_DECAY) : 1;
  logic [LVL_W-1:0] peak     [COLS];
  logic [LVL_W-1:0] peak_dec [COLS];
  logic [FW-1:0]    frm_cnt;
  logic             decay;

  assign decay = fs && (frm_cnt == FW'(PEAK_DECAY - 1));

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      peak_dec[c] = (decay && peak[c] != '0) ? peak[c] - LVL_W'(1) : peak[c];
    end
  end

  // Decay first, then take the max against a committing level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt <= '0;
      for (int c = 0; c < COLS; c++) peak[c] <= '0;
    end else begin
      if (fs) frm_cnt <= decay ? '0 : frm_cnt + FW'(1);
      for (int c = 0; c < COLS; c++) begin
        if (commit_now && load_bank[c] > peak_dec[c]) peak[c] <= load_bank[c];
        else                                           peak[c] <= peak_dec[c];
      end
    end
  end
`else
  logic unused_peak;
  assign unused_peak = ^{PEAK_C, 8'(PEAK_DECAY)};
`endif

  always_comb begin
    cur_row   = fs ? '0 : row;
    cur_col   = fs ? '0 : col;
    cur_addr  = fs ? '0 : addr;
    cur_lvl   = active_bank[cur_col];
    cell_h    = ROWS - 1 - int'(cur_row);
    cur_color = BG_C;
    if (cell_h < int'(cur_lvl)) begin
      if (cell_h < ROWS / 2)            cur_color = GREEN_C;
      else if (cell_h < (3 * ROWS) / 4) cur_color = YELLOW_C;
      else                              cur_color = RED_C;
    end
`ifdef SPECTRUM_PEAK_HOLD_EN
    else if (peak[cur_col] > cur_lvl && cell_h == int'(peak[cur_col]) - 1) begin
      cur_color = PEAK_C;
    end
`endif
  end

  // A frame start always (re)starts the sweep at cell 0; mid-sweep it flags an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      addr        <= '0;
      ram_addr    <= '0;
      write_color <= '0;
      write_en    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      if (fs || state == SWEEP) begin
        write_en    <= 1'b1;
        busy        <= 1'b1;
        ram_addr    <= cur_addr;
        write_color <= cur_color;
        overrun     <= fs && (state == SWEEP);
        frame_done  <= (state == DONE);
        addr        <= cur_addr + 10'd1;
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
        state <= (cur_addr == ADDR_LAST) ? DONE : SWEEP;
      end else if (state == DONE) begin
        write_en   <= 1'b0;
        busy       <= 1'b0;
        frame_done <= 1'b1;
        state      <= IDLE;
      end else begin
        write_en <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

endmodule
